// File: rtl/button_conditioner_pkg.sv
// Shared types and defaults for the push-button conditioner.
package button_conditioner_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } deb_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: invert, 2-flop synchronizer, debounce FSM with qualification counter.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_button_n_raw,
  output logic o_level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  deb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  deb_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_level_nxt;

  // Synchronizer, state, counter and output register; reset reads as button released.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync1 <= ~i_button_n_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_LOW: begin
        if (r_sync2) begin
          w_state_nxt = S_RISE_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      S_RISE_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = S_LOW;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = S_HIGH;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = S_FALL_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      S_FALL_WAIT: begin
        if (r_sync2) begin
          w_state_nxt = S_HIGH;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = S_LOW;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
    // Output register tracks the next state so it changes on the same edge as the state.
    w_level_nxt = (w_state_nxt == S_HIGH) || (w_state_nxt == S_FALL_WAIT);
  end

  assign o_level = r_level;

endmodule

// File: rtl/button_conditioner.sv
// Three independent debounced button channels feeding the controller's LoadA/LoadB/Execute.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic LoadA_n_raw,
  input  logic LoadB_n_raw,
  input  logic Execute_n_raw,
  output logic LoadA,
  output logic LoadB,
  output logic Execute
);

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_a (
    .Clk            (Clk),
    .Reset          (Reset),
    .i_button_n_raw (LoadA_n_raw),
    .o_level        (LoadA)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_b (
    .Clk            (Clk),
    .Reset          (Reset),
    .i_button_n_raw (LoadB_n_raw),
    .o_level        (LoadB)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_execute (
    .Clk            (Clk),
    .Reset          (Reset),
    .i_button_n_raw (Execute_n_raw),
    .o_level        (Execute)
  );

endmodule
